// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: default parameters, FSM states, redirect sources.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  localparam int          DEF_RAS_DEPTH = 4;

  // Instructions are halfword aligned; bit 0 of any PC is always forced low.
  localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    BRANCH = 3'd1,
    RET    = 3'd2,
    CALL   = 3'd3,
    JUMP   = 3'd4
  } redirect_src_t;

  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with sticky overflow/underflow flags.
// Latency: push/pop update state on the next edge; pop data is combinational from the top entry.
// Backpressure: none; a push when full evicts the oldest entry, a pop when empty returns EMPTY_ADDR.
module return_address_stack #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] EMPTY_ADDR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [15:0] i_push_addr,
  input  logic        i_pop,
  output logic [15:0] o_pop_addr,
  output logic        o_overflow,
  output logic        o_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_next_idx;

  // Pointer neighbours with explicit wrap so non-power-of-two depths also work.
  always_comb begin
    w_top_idx  = (r_wr_ptr == '0)       ? LAST_IDX : r_wr_ptr - PTR_W'(1);
    w_next_idx = (r_wr_ptr == LAST_IDX) ? '0       : r_wr_ptr + PTR_W'(1);
    o_pop_addr = (r_count == '0)        ? EMPTY_ADDR : r_mem[w_top_idx];
  end

  // Entry storage; contents are don't-care after reset since count gates reads.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_push) begin
      r_mem[r_wr_ptr] <= i_push_addr;
    end
  end

  // Pointer, occupancy and sticky error flags. When full the write slot is the
  // oldest entry, so overwriting it and advancing the pointer evicts it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_push) begin
      r_wr_ptr <= w_next_idx;
      if (r_count == FULL_CNT) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop) begin
      if (r_count == '0) begin
        r_underflow <= 1'b1;
      end else begin
        r_wr_ptr <= w_top_idx;
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC sequencer: prioritised redirects, stall hold, BOOT/RUN/BUBBLE tracking, return-address stack.
// Latency: redirect reaches pc one edge later; the first correct-path fetch is valid one edge after that.
// Backpressure: stall holds pc and fetch_valid unless a redirect arrives in the same cycle.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter int          RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_jump,
  input  logic [15:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  input  logic        i_call,
  input  logic [15:0] i_call_target,
  input  logic [15:0] i_return_addr,
  input  logic        i_ret,
  output logic [15:0] o_pc,
  output logic        o_fetch_valid,
  output logic        o_kill,
  output logic        o_ras_overflow,
  output logic        o_ras_underflow
);

  fetch_state_t  r_state;
  logic [15:0]   r_pc;
  logic          r_fetch_valid;
  logic          r_kill;

  redirect_src_t w_src;
  logic [15:0]   w_target;
  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_ras_pop_addr;
  logic [15:0]   w_pc_inc;

  // Redirect priority mux: branch beats ret beats call beats jump; only the winner acts.
  always_comb begin
    w_src    = NONE;
    w_target = 16'h0000;
    if (i_branch_taken) begin
      w_src    = BRANCH;
      w_target = i_branch_target;
    end else if (i_ret) begin
      w_src    = RET;
      w_target = w_ras_pop_addr;
    end else if (i_call) begin
      w_src    = CALL;
      w_target = i_call_target;
    end else if (i_jump) begin
      w_src    = JUMP;
      w_target = i_jump_target;
    end
    w_redirect = (w_src != NONE);
    w_push     = (w_src == CALL);
    w_pop      = (w_src == RET);
    w_pc_inc   = r_pc + 16'd2;
  end

  return_address_stack #(
    .DEPTH      (RAS_DEPTH),
    .EMPTY_ADDR (RESET_PC)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_addr (align_pc(i_return_addr)),
    .i_pop       (w_pop),
    .o_pop_addr  (w_ras_pop_addr),
    .o_overflow  (o_ras_overflow),
    .o_underflow (o_ras_underflow)
  );

  // Fetch FSM with registered pc/fetch_valid/kill; redirect wins over stall from any state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_kill        <= 1'b0;
    end else if (w_redirect) begin
      r_state       <= BUBBLE;
      r_pc          <= align_pc(w_target);
      r_fetch_valid <= 1'b0;
      r_kill        <= 1'b1;
    end else begin
      case (r_state)
        BOOT, RUN, BUBBLE: begin
          if (!i_stall) begin
            r_state       <= RUN;
            r_pc          <= w_pc_inc;
            r_fetch_valid <= 1'b1;
            r_kill        <= 1'b0;
          end
        end
        default: begin
          r_state       <= BOOT;
          r_fetch_valid <= 1'b0;
          r_kill        <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_fetch_valid = r_fetch_valid;
  assign o_kill        = r_kill;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random traffic vs. a queue-based model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: stall is driven randomly; the model applies the same hold rules.
module tb_fetch_controller;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, jump, br, call, ret;
  logic [15:0] jt, bt, ct, ra;

  logic [15:0] o_pc;
  logic        o_fetch_valid, o_kill, o_ras_overflow, o_ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each output should hold after the most recent edge.
  logic [15:0] m_pc;
  logic        m_fv, m_kill, m_ovf, m_unf;
  logic [15:0] m_ras[$];

  always #5 clk = ~clk;

  fetch_controller #(
    .RESET_PC  (RST_PC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_jump          (jump),
    .i_jump_target   (jt),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_call          (call),
    .i_call_target   (ct),
    .i_return_addr   (ra),
    .i_ret           (ret),
    .o_pc            (o_pc),
    .o_fetch_valid   (o_fetch_valid),
    .o_kill          (o_kill),
    .o_ras_overflow  (o_ras_overflow),
    .o_ras_underflow (o_ras_underflow)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0;
    jump = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
    jt = 16'h0; bt = 16'h0; ct = 16'h0; ra = 16'h0;
  endtask

  // Behavioural next-state rule, evaluated on the inputs presented for the coming edge.
  task automatic model_step();
    logic [15:0] tgt;
    bit          redir;
    if (!rst_n) begin
      m_pc = RST_PC; m_fv = 1'b0; m_kill = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
      return;
    end
    redir = 1'b1;
    tgt   = 16'h0;
    if (br) begin
      tgt = bt;
    end else if (ret) begin
      if (m_ras.size() == 0) begin
        tgt   = RST_PC;
        m_unf = 1'b1;
      end else begin
        tgt = m_ras.pop_back();
      end
    end else if (call) begin
      m_ras.push_back(ra & 16'hFFFE);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      tgt = ct;
    end else if (jump) begin
      tgt = jt;
    end else begin
      redir = 1'b0;
    end
    if (redir) begin
      m_pc = tgt & 16'hFFFE; m_fv = 1'b0; m_kill = 1'b1;
    end else if (!stall) begin
      m_pc = m_pc + 16'd2;   m_fv = 1'b1; m_kill = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_pc",  o_pc,                     m_pc);
    check("model_fv",  {15'd0, o_fetch_valid},   {15'd0, m_fv});
    check("model_kill",{15'd0, o_kill},          {15'd0, m_kill});
    check("model_ovf", {15'd0, o_ras_overflow},  {15'd0, m_ovf});
    check("model_unf", {15'd0, o_ras_underflow}, {15'd0, m_unf});
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h0050; exp_ret[1] = 16'h0040;
    exp_ret[2] = 16'h0030; exp_ret[3] = 16'h0020;
    m_pc = 16'h0; m_fv = 1'b0; m_kill = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state, then reset held across a stall cycle.
    idle();
    rst_n = 1'b0; stall = 1'b1; br = 1'b1; bt = 16'h1234;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("rst_pc",   o_pc, 16'h0000);
    check("rst_fv",   {15'd0, o_fetch_valid}, 16'd0);
    check("rst_kill", {15'd0, o_kill}, 16'd0);
    check("rst_flags",{14'd0, o_ras_overflow, o_ras_underflow}, 16'd0);

    // Free-running fetch after reset release; a stall in BOOT holds.
    rst_n = 1'b1; stall = 1'b1;
    tick();
    check("boot_stall_pc", o_pc, 16'h0000);
    stall = 1'b0;
    tick(); check("seq_pc1", o_pc, 16'h0002); check("seq_fv1", {15'd0, o_fetch_valid}, 16'd1);
    tick(); check("seq_pc2", o_pc, 16'h0004);
    tick(); check("seq_pc3", o_pc, 16'h0006);

    // Jump to an odd target from pc=0004.
    do_reset(); tick(); tick();
    check("jmp_pre_pc", o_pc, 16'h0004);
    jump = 1'b1; jt = 16'h0015;
    tick(); idle();
    check("jmp_pc",   o_pc, 16'h0014);
    check("jmp_kill", {15'd0, o_kill}, 16'd1);
    check("jmp_fv",   {15'd0, o_fetch_valid}, 16'd0);
    tick();
    check("jmp_pc2",  o_pc, 16'h0016);
    check("jmp_fv2",  {15'd0, o_fetch_valid}, 16'd1);

    // Branch beats ret and call, under stall; no push, no pop.
    stall = 1'b1; br = 1'b1; bt = 16'h0040; ret = 1'b1; call = 1'b1; ct = 16'h0300; ra = 16'h0310;
    tick(); idle();
    check("prio_pc",    o_pc, 16'h0040);
    check("prio_flags", {14'd0, o_ras_overflow, o_ras_underflow}, 16'd0);
    ret = 1'b1;
    tick(); idle();
    check("prio_empty_unf", {15'd0, o_ras_underflow}, 16'd1);
    check("prio_empty_pc",  o_pc, RST_PC);

    // Overflow on the fifth call, then four good returns and an underflow.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      call = 1'b1; ct = 16'(i * 256); ra = 16'(i * 16);
      tick();
      if (i == 4) check("ovf_pre", {15'd0, o_ras_overflow}, 16'd0);
    end
    idle();
    check("ovf_set", {15'd0, o_ras_overflow}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1;
      tick();
      check("ret_pc", o_pc, exp_ret[i]);
    end
    check("unf_pre", {15'd0, o_ras_underflow}, 16'd0);
    tick(); idle();
    check("unf_pc",  o_pc, RST_PC);
    check("unf_set", {15'd0, o_ras_underflow}, 16'd1);

    // PC wrap.
    jump = 1'b1; jt = 16'hFFFE;
    tick(); idle();
    check("wrap_pre", o_pc, 16'hFFFE);
    tick();
    check("wrap_pc",  o_pc, 16'h0000);

    // Reset during BUBBLE with a pushed entry discards everything.
    do_reset();
    call = 1'b1; ct = 16'h0200; ra = 16'h0080;
    tick(); idle();
    check("bub_kill", {15'd0, o_kill}, 16'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_pc",    o_pc, RST_PC);
    check("midrst_fv",    {15'd0, o_fetch_valid}, 16'd0);
    check("midrst_kill",  {15'd0, o_kill}, 16'd0);
    check("midrst_flags", {14'd0, o_ras_overflow, o_ras_underflow}, 16'd0);
    rst_n = 1'b1; ret = 1'b1;
    tick(); idle();
    check("midrst_unf", {15'd0, o_ras_underflow}, 16'd1);
    check("midrst_ret_pc", o_pc, RST_PC);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 7) == 0);
      ret   = ($urandom_range(0, 5) == 0);
      call  = ($urandom_range(0, 4) == 0);
      jump  = ($urandom_range(0, 7) == 0);
      jt = 16'($urandom); bt = 16'($urandom);
      ct = 16'($urandom); ra = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset and used as the underflow return target.
REQ-002 Parameter RAS_DEPTH, default 4, meaning the number of return-address-stack entries.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  holds PC and fetch-valid state.
REQ-006 jump  input  1, jump_target  input  16  unconditional redirect request.
REQ-007 branch_taken  input  1, branch_target  input  16  resolved-taken branch redirect request.
REQ-008 call  input  1, call_target  input  16, return_addr  input  16  call redirect plus push request.
REQ-009 ret  input  1  pop-and-redirect request.
REQ-010 pc  output  16  registered byte address driven to instruction memory.
REQ-011 fetch_valid  output  1  high when the instruction memory output this cycle is a correct-path instruction.
REQ-012 kill  output  1  registered, equal to ~fetch_valid while not in BOOT; flushes IF/ID.
REQ-013 ras_overflow, ras_underflow  output  1 each  sticky error flags.

Function
REQ-014 Redirect priority, highest first: branch_taken, ret, call, jump; only the winner acts, and losers cause no PC change, push or pop.
REQ-015 A redirect SHALL override stall in the same cycle.
REQ-016 Per edge: on redirect, pc <= target & 16'hFFFE and fetch_valid <= 0; else on stall, pc and fetch_valid hold; else pc <= pc + 2 and fetch_valid <= 1.
REQ-017 The PC increment SHALL wrap modulo 2^16, so 16'hFFFE is followed by 16'h0000.
REQ-018 The block SHALL implement states BOOT, RUN and BUBBLE.
REQ-019 State transitions: BOOT, entered on reset, goes to RUN on the first non-stalled edge; RUN goes to BUBBLE on redirect; BUBBLE goes to RUN on the next non-stalled, non-redirect edge; a redirect in BUBBLE stays in BUBBLE.
REQ-020 fetch_valid SHALL be 0 in BOOT and BUBBLE and 1 in RUN.
REQ-021 kill SHALL be 1 only in BUBBLE.
REQ-022 A call that wins SHALL push return_addr & 16'hFFFE onto the RAS.
REQ-023 When the RAS is full, a push SHALL discard the oldest entry (circular) and set ras_overflow.
REQ-024 A ret that wins SHALL pop the RAS and redirect to the popped value.
REQ-025 When the RAS is empty, a ret SHALL redirect to RESET_PC, set ras_underflow, and leave the count at 0.
REQ-026 Push and pop SHALL never occur in the same cycle, as guaranteed by REQ-014.
REQ-027 The RAS count SHALL stay in 0..RAS_DEPTH and never wrap.
REQ-028 Redirect-to-pc latency SHALL be exactly 1 cycle, and the first correct-path instruction SHALL appear 1 cycle after that.

Reset
REQ-029 While rst_n = 0 at an edge: pc <= RESET_PC, state <= BOOT, fetch_valid <= 0, kill <= 0, RAS count <= 0, ras_overflow <= 0, ras_underflow <= 0.
REQ-030 Reset SHALL override stall and all redirect inputs.
REQ-031 Reset asserted mid-BUBBLE or with a pending push SHALL discard all in-flight state.
REQ-032 RAS entry contents need not be cleared on reset.

Structure
REQ-033 A shared package fetch_pkg SHALL hold RESET_PC and RAS_DEPTH defaults, the state enum (BOOT, RUN, BUBBLE) and the redirect-source enum (NONE, BRANCH, RET, CALL, JUMP).
REQ-034 Sub-module return_address_stack SHALL own push, pop, count, overflow and underflow, with pop data combinational from the top entry.
REQ-035 The priority mux and state machine SHALL reside in fetch_controller.

Verification
REQ-036 Release reset with no stall and no requests -> pc sequence 0000, 0002, 0004, 0006; fetch_valid 0 in the first cycle, then 1.
REQ-037 jump=1 with jump_target=16'h0015 at pc=0004 -> next pc=0014, then 0016; fetch_valid=0 and kill=1 for one cycle.
REQ-038 branch_taken (target 0040), ret and call all asserted together with stall=1 -> pc=0040, RAS count unchanged, no flags set.
REQ-039 Five calls with return_addr 0010, 0020, 0030, 0040, 0050, then five rets -> ras_overflow=1; rets redirect to 0050, 0040, 0030, 0020, then RESET_PC with ras_underflow=1.
REQ-040 pc=FFFE with no requests -> next pc=0000.
REQ-041 rst_n=0 for one cycle during BUBBLE with a pushed RAS entry -> pc=RESET_PC, state BOOT, count 0, flags 0; a following ret sets ras_underflow.
